// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared constants, state type and helpers for the 8-to-3 encoder
package enc_pkg;

   localparam int N  = 8;
   localparam int IW = $clog2(N);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } enc_state_t;

   // True when exactly one bit of v is set: v is non-zero and clearing its
   // lowest set bit leaves nothing behind.
   function automatic logic onehot_count_is_one(input logic [N-1:0] v);
      logic [N-1:0] v_minus_one;
      v_minus_one = v - {{(N-1){1'b0}}, 1'b1};
      return (v != '0) && ((v & v_minus_one) == '0);
   endfunction

endpackage

// File: rtl/prio_enc8_3.sv
// rtl/prio_enc8_3.sv - combinational 8-to-3 priority encoder with selectable direction
module prio_enc8_3
   import enc_pkg::*;
#(
   parameter bit LOW_FIRST = 1'b1
) (
   input  logic [N-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scan so that the winning bit is the last one written: walking downward
   // leaves the lowest set bit, walking upward leaves the highest. An all-zero
   // vector encodes to index 0.
   always_comb begin
      idx = '0;
      any = 1'b0;
      if (LOW_FIRST) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
               idx = IW'(i);
               any = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
               idx = IW'(i);
               any = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/encoder8_3_seq.sv
// rtl/encoder8_3_seq.sv - sequential 8-to-3 encoder draining a multi-hot word one index per beat
module encoder8_3_seq
   import enc_pkg::*;
#(
   parameter bit LOW_FIRST = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          req_valid,
   output logic          req_ready,
   output logic [IW-1:0] out_index,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic          busy
);

   enc_state_t    state;
   logic [N-1:0]  pending;
   logic [IW-1:0] prio_idx;
   logic          pending_any;
   logic          pending_single;
   logic [N-1:0]  clear_mask;
   logic          beat_done;

   prio_enc8_3 #(
      .LOW_FIRST (LOW_FIRST)
   ) u_prio (
      .vec (pending),
      .idx (prio_idx),
      .any (pending_any)
   );

   // Output decode from registered state and pending; out_ready never feeds
   // out_valid, so a stalled consumer sees stable index and last flags.
   always_comb begin
      pending_single = onehot_count_is_one(pending);
      req_ready      = (state == IDLE);
      busy           = (state == DRAIN);
      out_valid      = (state == DRAIN) && pending_any;
      out_index      = prio_idx;
      out_last       = (state == DRAIN) && pending_single;
      beat_done      = out_valid && out_ready;
      clear_mask     = '0;
      clear_mask[prio_idx] = 1'b1;
   end

   // FSM and pending register: latch a non-zero word in IDLE, retire one bit
   // per handshake in DRAIN, return to IDLE after the last beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pending <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && (req != '0)) begin
                  pending <= req;
                  state   <= DRAIN;
               end
            end
            DRAIN: begin
               if (beat_done) begin
                  pending <= pending & ~clear_mask;
                  if (out_last) begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               pending <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_encoder8_3_seq.sv
// tb/tb_encoder8_3_seq.sv - directed self-checking bench for encoder8_3_seq
module tb_encoder8_3_seq;

   logic       clk;
   logic       reset;
   logic [7:0] req;
   logic       req_valid;
   logic       out_ready;

   logic       req_ready_lo, out_valid_lo, out_last_lo, busy_lo;
   logic [2:0] out_index_lo;
   logic       req_ready_hi, out_valid_hi, out_last_hi, busy_hi;
   logic [2:0] out_index_hi;

   int checks;
   int errors;

   encoder8_3_seq #(.LOW_FIRST(1'b1)) dut_lo (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_valid (req_valid),
      .req_ready (req_ready_lo),
      .out_index (out_index_lo),
      .out_valid (out_valid_lo),
      .out_ready (out_ready),
      .out_last  (out_last_lo),
      .busy      (busy_lo)
   );

   encoder8_3_seq #(.LOW_FIRST(1'b0)) dut_hi (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_valid (req_valid),
      .req_ready (req_ready_hi),
      .out_index (out_index_hi),
      .out_valid (out_valid_hi),
      .out_ready (out_ready),
      .out_last  (out_last_hi),
      .busy      (busy_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 8'h00; req_valid = 1'b0; out_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
      checks++; if (req_ready_lo !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready_lo); end
      checks++; if (out_valid_lo !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_lo); end
      checks++; if (busy_lo !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_lo); end
      checks++; if (out_index_lo !== 3'd0) begin errors++; $display("FAIL reset_out_index got=%0d exp=0", out_index_lo); end
      checks++; if (out_last_lo !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last_lo); end
      checks++; if (req_ready_hi !== 1'b1) begin errors++; $display("FAIL reset_hi_req_ready got=%b exp=1", req_ready_hi); end
   endtask

   task automatic test_basic();
      logic [2:0] exp_idx [3];
      exp_idx[0] = 3'd2; exp_idx[1] = 3'd5; exp_idx[2] = 3'd7;
      req = 8'b1010_0100; req_valid = 1'b1; out_ready = 1'b1;
      step();
      req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++; if (out_valid_lo !== 1'b1) begin errors++; $display("FAIL basic_valid beat=%0d got=%b exp=1", k, out_valid_lo); end
         checks++; if (out_index_lo !== exp_idx[k]) begin errors++; $display("FAIL basic_index beat=%0d got=%0d exp=%0d", k, out_index_lo, exp_idx[k]); end
         checks++; if (out_last_lo !== (k == 2)) begin errors++; $display("FAIL basic_last beat=%0d got=%b exp=%b", k, out_last_lo, (k == 2)); end
         checks++; if (req_ready_lo !== 1'b0 || busy_lo !== 1'b1) begin errors++; $display("FAIL basic_busy beat=%0d ready=%b busy=%b exp ready=0 busy=1", k, req_ready_lo, busy_lo); end
         step();
      end
      checks++; if (req_ready_lo !== 1'b1) begin errors++; $display("FAIL basic_ready_after got=%b exp=1", req_ready_lo); end
      checks++; if (out_valid_lo !== 1'b0 || busy_lo !== 1'b0) begin errors++; $display("FAIL basic_idle_after valid=%b busy=%b exp 0 0", out_valid_lo, busy_lo); end
   endtask

   task automatic test_stall();
      req = 8'b1000_0001; req_valid = 1'b1; out_ready = 1'b0;
      step();
      req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++; if (out_valid_lo !== 1'b1) begin errors++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", k, out_valid_lo); end
         checks++; if (out_index_lo !== 3'd0) begin errors++; $display("FAIL stall_index cyc=%0d got=%0d exp=0", k, out_index_lo); end
         checks++; if (out_last_lo !== 1'b0) begin errors++; $display("FAIL stall_last cyc=%0d got=%b exp=0", k, out_last_lo); end
         step();
      end
      out_ready = 1'b1;
      checks++; if (out_index_lo !== 3'd0 || out_valid_lo !== 1'b1) begin errors++; $display("FAIL stall_release_first idx=%0d valid=%b exp idx=0 valid=1", out_index_lo, out_valid_lo); end
      step();
      checks++; if (out_index_lo !== 3'd7 || out_last_lo !== 1'b1) begin errors++; $display("FAIL stall_second idx=%0d last=%b exp idx=7 last=1", out_index_lo, out_last_lo); end
      step();
      checks++; if (req_ready_lo !== 1'b1 || out_valid_lo !== 1'b0) begin errors++; $display("FAIL stall_idle ready=%b valid=%b exp 1 0", req_ready_lo, out_valid_lo); end
   endtask

   task automatic test_zero_word();
      req = 8'h00; req_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (out_valid_lo !== 1'b0 || busy_lo !== 1'b0 || req_ready_lo !== 1'b1) begin errors++; $display("FAIL zero_word cyc=%0d valid=%b busy=%b ready=%b exp 0 0 1", k, out_valid_lo, busy_lo, req_ready_lo); end
      end
      req_valid = 1'b0;
   endtask

   task automatic test_high_first();
      req = 8'hFF; req_valid = 1'b1; out_ready = 1'b1;
      step();
      req = 8'h0F;
      for (int k = 0; k < 8; k++) begin
         req_valid = (k < 7);
         checks++; if (out_valid_hi !== 1'b1) begin errors++; $display("FAIL hi_valid beat=%0d got=%b exp=1", k, out_valid_hi); end
         checks++; if (out_index_hi !== 3'(7 - k)) begin errors++; $display("FAIL hi_index beat=%0d got=%0d exp=%0d", k, out_index_hi, 7 - k); end
         checks++; if (out_last_hi !== (k == 7)) begin errors++; $display("FAIL hi_last beat=%0d got=%b exp=%b", k, out_last_hi, (k == 7)); end
         checks++; if (req_ready_hi !== 1'b0) begin errors++; $display("FAIL hi_ready_in_drain beat=%0d got=%b exp=0", k, req_ready_hi); end
         checks++; if (out_index_lo !== 3'(k) || out_last_lo !== (k == 7)) begin errors++; $display("FAIL lo_ff beat=%0d idx=%0d last=%b exp idx=%0d last=%b", k, out_index_lo, out_last_lo, k, (k == 7)); end
         step();
      end
      checks++; if (req_ready_hi !== 1'b1 || out_valid_hi !== 1'b0) begin errors++; $display("FAIL hi_idle_after ready=%b valid=%b exp 1 0", req_ready_hi, out_valid_hi); end
      checks++; if (busy_lo !== 1'b0) begin errors++; $display("FAIL lo_ff_ignored_req busy=%b exp=0", busy_lo); end
   endtask

   task automatic test_reset_mid_drain();
      req = 8'hF0; req_valid = 1'b1; out_ready = 1'b1;
      step();
      req_valid = 1'b0;
      checks++; if (out_index_lo !== 3'd4) begin errors++; $display("FAIL mid_first idx=%0d exp=4", out_index_lo); end
      step();
      checks++; if (out_index_lo !== 3'd5) begin errors++; $display("FAIL mid_second idx=%0d exp=5", out_index_lo); end
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (out_valid_lo !== 1'b0 || req_ready_lo !== 1'b1 || busy_lo !== 1'b0) begin errors++; $display("FAIL mid_reset valid=%b ready=%b busy=%b exp 0 1 0", out_valid_lo, req_ready_lo, busy_lo); end
      req = 8'h02; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      checks++; if (out_valid_lo !== 1'b1 || out_index_lo !== 3'd1 || out_last_lo !== 1'b1) begin errors++; $display("FAIL post_reset_word valid=%b idx=%0d last=%b exp 1 1 1", out_valid_lo, out_index_lo, out_last_lo); end
      step();
      checks++; if (out_valid_lo !== 1'b0 || req_ready_lo !== 1'b1) begin errors++; $display("FAIL post_reset_idle valid=%b ready=%b exp 0 1", out_valid_lo, req_ready_lo); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_stall();
      test_zero_word();
      test_high_first();
      test_reset_mid_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
